palette_sprite_ctrl: RTL and testbench

Sprite palette controller for the PPU sprite-draw path. It owns the 4-palette × 4-colour sprite palette storage and accepts CPU palette writes through a 4-deep write FIFO. Buffered writes are committed only during vertical blanking, so on-screen colours never change mid-frame. It also serves the sprite pixel pipeline with a registered read port that returns all four colours of one palette.

---
 rtl/palette_sprite_ctrl.sv | 87 ++++++++
 tb/tb_palette_sprite_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/palette_sprite_ctrl.sv
// palette_sprite_ctrl: 4x4 sprite palette fed by a 4-deep write FIFO; SPRITE_PAL_VBLANK_GATE_EN restricts commits to vblank
module palette_sprite_ctrl #(
    parameter int RGB_BIT    = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               vblank,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [3:0]         wr_addr,
    input  logic [RGB_BIT-1:0] wr_data,
    input  logic               rd_en,
    input  logic [1:0]         rd_palette,
    output logic [RGB_BIT-1:0] rd_color00,
    output logic [RGB_BIT-1:0] rd_color01,
    output logic [RGB_BIT-1:0] rd_color10,
    output logic [RGB_BIT-1:0] rd_color11,
    output logic               rd_valid,
    output logic [2:0]         fifo_level,
    output logic               commit_done
);
    typedef enum logic [1:0] {IDLE, DRAIN, HOLD} state_t;
    state_t state, state_nx;
    logic [RGB_BIT-1:0] pal [16];
    logic [RGB_BIT-1:0] q_data [4];
    logic [3:0] q_addr [4];
    logic [1:0] wp, rp;
    logic gate, push, pop;
    logic [2:0] level_nx;
`ifdef SPRITE_PAL_VBLANK_GATE_EN
    assign gate = vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign gate = 1'b1;
`endif
    assign wr_ready = fifo_level != 3'(FIFO_DEPTH);
    assign push = wr_valid && wr_ready;
    assign pop = fifo_level != 3'd0 && gate;
    always_comb begin
        level_nx = fifo_level + 3'(push) - 3'(pop);
        state_nx = level_nx == 3'd0 ? IDLE : gate ? DRAIN : HOLD;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 16; i++) pal[i] <= '0;
            for (int i = 0; i < 4; i++) begin
                q_data[i] <= '0;
                q_addr[i] <= '0;
            end
            wp <= '0;
            rp <= '0;
            fifo_level <= '0;
            commit_done <= 1'b0;
            rd_valid <= 1'b0;
            rd_color00 <= '0;
            rd_color01 <= '0;
            rd_color10 <= '0;
            rd_color11 <= '0;
        end else begin
            if (push) begin
                q_addr[wp] <= wr_addr;
                q_data[wp] <= wr_data;
                wp <= wp + 2'd1;
            end
            if (pop) begin
                pal[q_addr[rp]] <= q_data[rp];
                rp <= rp + 2'd1;
            end
            fifo_level <= level_nx;
            commit_done <= state != IDLE && state_nx == IDLE;
            rd_valid <= rd_en;
            // reads sample pre-commit storage, so a same-edge commit is not visible yet
            if (rd_en) begin
                rd_color00 <= pal[{rd_palette, 2'd0}];
                rd_color01 <= pal[{rd_palette, 2'd1}];
                rd_color10 <= pal[{rd_palette, 2'd2}];
                rd_color11 <= pal[{rd_palette, 2'd3}];
            end
        end
    end
endmodule

// File: tb/tb_palette_sprite_ctrl.sv
// tb_palette_sprite_ctrl: directed bench with a read scoreboard for palette_sprite_ctrl
module tb_palette_sprite_ctrl;
    logic clk = 1'b0;
    logic rstn, vblank, wr_valid, rd_en, wr_ready, rd_valid, commit_done;
    logic [3:0] wr_addr;
    logic [11:0] wr_data, rd_color00, rd_color01, rd_color10, rd_color11;
    logic [1:0] rd_palette;
    logic [2:0] fifo_level;
    int tests = 0;
    int fails = 0;
    logic [47:0] sb [$];

    palette_sprite_ctrl #(.RGB_BIT(12), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rstn(rstn), .vblank(vblank), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_palette(rd_palette),
        .rd_color00(rd_color00), .rd_color01(rd_color01), .rd_color10(rd_color10),
        .rd_color11(rd_color11), .rd_valid(rd_valid), .fifo_level(fifo_level),
        .commit_done(commit_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [11:0] d);
        wr_valid = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic rd(input logic [1:0] p, input logic [47:0] e);
        rd_en = 1'b1;
        rd_palette = p;
        sb.push_back(e);
        tick();
        rd_en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rstn && rd_valid) begin
            if (sb.size() == 0) chk("rd_unexpected", {63'd0, rd_valid}, 64'd0);
            else chk("rd_data", {16'd0, rd_color11, rd_color10, rd_color01, rd_color00}, {16'd0, sb.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; vblank = 1'b0; wr_valid = 1'b1; wr_addr = 4'h5; wr_data = 12'hABC;
        rd_en = 1'b0; rd_palette = 2'd0;
        repeat (3) tick();
        chk("rst_ready", wr_ready, 1);
        chk("rst_level", fifo_level, 0);
        chk("rst_done", commit_done, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_colors", {rd_color11, rd_color10, rd_color01, rd_color00}, 0);
        wr_valid = 1'b0;
        rstn = 1'b1;
        tick();
        chk("rst_write_ignored", fifo_level, 0);
        rd(2'd2, 48'h0);
        chk("read_level", fifo_level, 0);
        chk("read_ready", wr_ready, 1);
        tick();
        chk("rd_pulse", rd_valid, 0);

        // single write, gated on vblank when the gate is built in
        wr(4'b0110, 12'hF0A);
        chk("gw_level", fifo_level, 1);
`ifdef SPRITE_PAL_VBLANK_GATE_EN
        rd(2'd1, 48'h0);
        chk("gw_hold_level", fifo_level, 1);
        chk("gw_hold_done", commit_done, 0);
        vblank = 1'b1;
`endif
        tick();
        chk("gw_done", commit_done, 1);
        chk("gw_level0", fifo_level, 0);
        vblank = 1'b0;
        tick();
        chk("gw_done_pulse", commit_done, 0);
        rd(2'd1, {12'h0, 12'hF0A, 12'h0, 12'h0});

        // wr_valid held six cycles
        wr_valid = 1'b1;
`ifdef SPRITE_PAL_VBLANK_GATE_EN
        for (int i = 0; i < 6; i++) begin
            wr_addr = 4'(i);
            wr_data = 12'(i + 1);
            chk("full_ready", wr_ready, i < 4);
            tick();
        end
        wr_valid = 1'b0;
        chk("full_level", fifo_level, 4);
        chk("full_ready_low", wr_ready, 0);
        vblank = 1'b1;
        for (int i = 3; i > 0; i--) begin
            tick();
            chk("full_drain_level", fifo_level, 64'(i));
            chk("full_drain_done", commit_done, 0);
        end
        tick();
        chk("full_empty", fifo_level, 0);
        chk("full_done", commit_done, 1);
        vblank = 1'b0;
        rd(2'd0, {12'h4, 12'h3, 12'h2, 12'h1});
        rd(2'd1, {12'h0, 12'hF0A, 12'h0, 12'h0});
`else
        for (int i = 0; i < 6; i++) begin
            wr_addr = 4'(i);
            wr_data = 12'(i + 1);
            chk("stream_ready", wr_ready, 1);
            tick();
            chk("stream_level", fifo_level, 1);
        end
        wr_valid = 1'b0;
        tick();
        chk("stream_empty", fifo_level, 0);
        chk("stream_done", commit_done, 1);
        rd(2'd0, {12'h4, 12'h3, 12'h2, 12'h1});
        rd(2'd1, {12'h0, 12'hF0A, 12'h6, 12'h5});
`endif

        // three queued writes to palette 2
`ifdef SPRITE_PAL_VBLANK_GATE_EN
        wr(4'd8, 12'hA1);
        wr(4'd9, 12'hA2);
        wr(4'd10, 12'hA3);
        chk("mid_level3", fifo_level, 3);
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        chk("mid_level2", fifo_level, 2);
        chk("mid_done0", commit_done, 0);
        tick();
        chk("mid_hold_level", fifo_level, 2);
        rd(2'd2, {12'h0, 12'h0, 12'h0, 12'hA1});
        vblank = 1'b1;
        tick();
        chk("mid_level1", fifo_level, 1);
        chk("mid_done1", commit_done, 0);
        tick();
        chk("mid_level0", fifo_level, 0);
        chk("mid_done", commit_done, 1);
        tick();
        chk("mid_done_pulse", commit_done, 0);
`else
        wr(4'd8, 12'hA1);
        wr(4'd9, 12'hA2);
        chk("burst_done_early", commit_done, 0);
        wr(4'd10, 12'hA3);
        chk("burst_level", fifo_level, 1);
        tick();
        chk("burst_level0", fifo_level, 0);
        chk("burst_done", commit_done, 1);
`endif
        rd(2'd2, {12'h0, 12'hA3, 12'hA2, 12'hA1});
        vblank = 1'b1;

        // same address twice: last write wins
        wr(4'd11, 12'hB1);
        wr(4'd11, 12'hB2);
        chk("same_level", fifo_level, 1);
        chk("same_done0", commit_done, 0);
        tick();
        chk("same_done", commit_done, 1);
        rd(2'd2, {12'hB2, 12'hA3, 12'hA2, 12'hA1});

        // read and commit of palette 0 on the same edge
        wr(4'd0, 12'h123);
        rd(2'd0, {12'h4, 12'h3, 12'h2, 12'h1});
        chk("coll_done", commit_done, 1);
        rd(2'd0, {12'h4, 12'h3, 12'h2, 12'h123});

        // reset while entries are still queued
`ifdef SPRITE_PAL_VBLANK_GATE_EN
        vblank = 1'b0;
        for (int i = 0; i < 4; i++) wr(4'(12 + i), 12'(12'hC1 + i));
        chk("rmd_level4", fifo_level, 4);
        vblank = 1'b1;
        tick();
        tick();
        chk("rmd_level2", fifo_level, 2);
`else
        wr(4'd12, 12'hC1);
        wr(4'd13, 12'hC2);
        chk("rmd_level1", fifo_level, 1);
`endif
        rstn = 1'b0;
        #1;
        chk("rmd_async_level", fifo_level, 0);
        chk("rmd_async_color", rd_color00, 0);
        chk("rmd_async_ready", wr_ready, 1);
        tick();
        chk("rmd_done", commit_done, 0);
        rstn = 1'b1;
        tick();
        chk("rmd_done_after", commit_done, 0);
        chk("rmd_level_after", fifo_level, 0);
        rd(2'd3, 48'h0);
        rd(2'd0, 48'h0);
        rd(2'd1, 48'h0);
        rd(2'd2, 48'h0);
        tick();
        tick();
        chk("sb_drained", 64'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
